// File: rtl/irrigation_timer_controller_if.sv
// rtl/irrigation_timer_controller_if.sv - signal bundle between valve logic and the irrigation timer
// Purpose: groups the request/abort/preset inputs and the countdown outputs.
// Ports (slave = timer side):
//   in : irrigation_on, conflicting_values, forced_reset,
//        load_minutes_d[1:0], load_minutes_u[3:0], load_seconds_d[2:0]
//   out: minutes_d[1:0], minutes_u[3:0], seconds_d[2:0], seconds_u[3:0],
//        running, expired, state[1:0]
interface irrigation_timer_controller_if;
  logic       irrigation_on;
  logic       conflicting_values;
  logic       forced_reset;
  logic [1:0] load_minutes_d;
  logic [3:0] load_minutes_u;
  logic [2:0] load_seconds_d;
  logic [1:0] minutes_d;
  logic [3:0] minutes_u;
  logic [2:0] seconds_d;
  logic [3:0] seconds_u;
  logic       running;
  logic       expired;
  logic [1:0] state;

  modport master (
    output irrigation_on, conflicting_values, forced_reset,
    output load_minutes_d, load_minutes_u, load_seconds_d,
    input  minutes_d, minutes_u, seconds_d, seconds_u,
    input  running, expired, state
  );

  modport slave (
    input  irrigation_on, conflicting_values, forced_reset,
    input  load_minutes_d, load_minutes_u, load_seconds_d,
    output minutes_d, minutes_u, seconds_d, seconds_u,
    output running, expired, state
  );
endinterface

// File: rtl/irrigation_timer_controller.sv
// rtl/irrigation_timer_controller.sv - BCD countdown timer for one irrigation run
// Purpose: on a rising irrigation_on, loads a clamped MM:S0 preset and counts
//   down one second per CLK_PER_SEC clocks; pauses while sensors conflict,
//   aborts on forced_reset or a dropped request, pulses expired at 00:00.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : irrigation_timer_controller_if.slave (requests, preset, BCD time, status)
module irrigation_timer_controller #(
  parameter int CLK_PER_SEC = 50000000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  irrigation_timer_controller_if.slave  bus
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    md_q, md_d;
  logic [3:0]    mu_q, mu_d;
  logic [2:0]    sd_q, sd_d;
  logic [3:0]    su_q, su_d;
  logic          expired_q, expired_d;
  logic          irr_q;

  logic          start;
  logic          tick;
  logic [3:0]    clamp_mu;
  logic [2:0]    clamp_sd;
  logic          preset_nz;

  assign start     = bus.irrigation_on & ~irr_q;
  assign tick      = (presc_q == PRESC_MAX);
  assign clamp_mu  = (bus.load_minutes_u > 4'd9) ? 4'd9 : bus.load_minutes_u;
  assign clamp_sd  = (bus.load_seconds_d > 3'd5) ? 3'd5 : bus.load_seconds_d;
  assign preset_nz = |{bus.load_minutes_d, clamp_mu, clamp_sd};

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    md_d      = md_q;
    mu_d      = mu_q;
    sd_d      = sd_q;
    su_d      = su_q;
    expired_d = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        md_d    = '0;
        mu_d    = '0;
        sd_d    = '0;
        su_d    = '0;
        if (start && !bus.forced_reset && preset_nz) begin
          md_d    = bus.load_minutes_d;
          mu_d    = clamp_mu;
          sd_d    = clamp_sd;
          state_d = bus.conflicting_values ? HOLD : RUN;
        end
      end

      RUN, HOLD: begin
        if (bus.forced_reset || !bus.irrigation_on) begin
          state_d = IDLE;
          presc_d = '0;
          md_d    = '0;
          mu_d    = '0;
          sd_d    = '0;
          su_d    = '0;
        end else if (bus.conflicting_values) begin
          // Everything freezes; a coinciding tick is simply not taken.
          state_d = HOLD;
        end else begin
          // The edge leaving HOLD already counts, so a pause of N
          // conflicting cycles delays expiry by exactly N cycles.
          state_d = RUN;
          if (tick) begin
            presc_d = '0;
            if ({md_q, mu_q, sd_q, su_q} == 13'd1) begin
              state_d   = DONE;
              expired_d = 1'b1;
              su_d      = '0;
            end else if (su_q != 4'd0) begin
              su_d = su_q - 4'd1;
            end else begin
              su_d = 4'd9;
              if (sd_q != 3'd0) begin
                sd_d = sd_q - 3'd1;
              end else begin
                sd_d = 3'd5;
                if (mu_q != 4'd0) begin
                  mu_d = mu_q - 4'd1;
                end else begin
                  mu_d = 4'd9;
                  md_d = md_q - 2'd1;
                end
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      DONE: begin
        md_d = '0;
        mu_d = '0;
        sd_d = '0;
        su_d = '0;
        if (bus.forced_reset || !bus.irrigation_on) begin
          state_d = IDLE;
          presc_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      md_q      <= '0;
      mu_q      <= '0;
      sd_q      <= '0;
      su_q      <= '0;
      expired_q <= 1'b0;
      irr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      md_q      <= md_d;
      mu_q      <= mu_d;
      sd_q      <= sd_d;
      su_q      <= su_d;
      expired_q <= expired_d;
      irr_q     <= bus.irrigation_on;
    end
  end

  assign bus.minutes_d = md_q;
  assign bus.minutes_u = mu_q;
  assign bus.seconds_d = sd_q;
  assign bus.seconds_u = su_q;
  assign bus.running   = (state_q == RUN);
  assign bus.expired   = expired_q;
  assign bus.state     = state_q;

endmodule
